// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I writeback slice.
//   wb_sel_e   : writeback result source selector
//   load_f3_e  : load-type funct3 codes
//   INSTRET_W  : width of the retired-instruction counter
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    localparam int unsigned INSTRET_W = 64;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load extraction: picks the byte/half lane from a word-aligned
// read, sign- or zero-extends it, and flags misaligned half/word accesses.
//   funct3     : load type (unlisted codes behave as LW)
//   addr       : low two bits of the effective address
//   rdata      : word-aligned memory read data
//   data       : extended load result
//   misaligned : access not naturally aligned for its size
module rv32i_load_align
    import rv32i_pkg::*;
#(
    parameter int unsigned Reg_width = 32
) (
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr,
    input  logic [Reg_width-1:0] rdata,
    output logic [Reg_width-1:0] data,
    output logic                 misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{addr, 3'b000} +: 8];
        half_v     = rdata[{addr[1], 4'b0000} +: 16];
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(Reg_width-8){byte_v[7]}}, byte_v};
            F3_LBU: data = {{(Reg_width-8){1'b0}}, byte_v};
            F3_LH: begin
                data       = {{(Reg_width-16){half_v[15]}}, half_v};
                misaligned = addr[0];
            end
            F3_LHU: begin
                data       = {{(Reg_width-16){1'b0}}, half_v};
                misaligned = addr[0];
            end
            default: begin
                data       = rdata;
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I MEM/WB pipeline register and writeback stage.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   in_*            : MEM-stage instruction fields (captured when valid, not flushed)
//   wb_enable       : register-file write strobe
//   wb_reg, wr_data : register-file write index and data (held while idle)
//   load_misaligned : one-cycle fault pulse for a misaligned load
//   fault_addr      : address of the most recent misaligned load
//   instret         : retired-instruction counter
module rv32i_writeback
    import rv32i_pkg::*;
#(
    parameter int unsigned Reg_width      = 32,
    parameter int unsigned Reg_depth_bits = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_flush,
    input  logic                      in_wb_en,
    input  logic [Reg_depth_bits-1:0] in_rd,
    input  logic [1:0]                in_wb_sel,
    input  logic [2:0]                in_funct3,
    input  logic [Reg_width-1:0]      in_alu_result,
    input  logic [Reg_width-1:0]      in_pc_plus4,
    input  logic [Reg_width-1:0]      in_mem_rdata,
    output logic                      wb_enable,
    output logic [Reg_depth_bits-1:0] wb_reg,
    output logic [Reg_width-1:0]      wr_data,
    output logic                      load_misaligned,
    output logic [Reg_width-1:0]      fault_addr,
    output logic [INSTRET_W-1:0]      instret
);

    logic                      valid_q;
    logic                      wb_en_q;
    logic [Reg_depth_bits-1:0] rd_q;
    wb_sel_e                   sel_q;
    logic [2:0]                funct3_q;
    logic [Reg_width-1:0]      alu_q;
    logic [Reg_width-1:0]      pc4_q;
    logic [Reg_width-1:0]      rdata_q;
    logic [Reg_width-1:0]      fault_q;
    logic [INSTRET_W-1:0]      instret_q;

    logic [Reg_width-1:0]      load_data;
    logic                      align_mis;
    logic                      misaligned_q;
    logic                      accept;

    assign accept = in_valid && !in_flush;

    // Fields are only overwritten on an accepted instruction, so the
    // write index/data naturally hold across idle or flushed cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            rd_q      <= '0;
            sel_q     <= WB_ALU;
            funct3_q  <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            rdata_q   <= '0;
            fault_q   <= '0;
            instret_q <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                wb_en_q  <= in_wb_en;
                rd_q     <= in_rd;
                sel_q    <= wb_sel_e'(in_wb_sel);
                funct3_q <= in_funct3;
                alu_q    <= in_alu_result;
                pc4_q    <= in_pc_plus4;
                rdata_q  <= in_mem_rdata;
            end
            if (misaligned_q) begin
                fault_q <= alu_q;
            end
            if (valid_q && !misaligned_q) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    rv32i_load_align #(
        .Reg_width (Reg_width)
    ) u_align (
        .funct3     (funct3_q),
        .addr       (alu_q[1:0]),
        .rdata      (rdata_q),
        .data       (load_data),
        .misaligned (align_mis)
    );

    assign misaligned_q = valid_q && (sel_q == WB_LOAD) && align_mis;

    always_comb begin
        wr_data = '0;
        case (sel_q)
            WB_ALU:  wr_data = alu_q;
            WB_LOAD: wr_data = load_data;
            WB_PC4:  wr_data = pc4_q;
            default: wr_data = '0;
        endcase
    end

    assign wb_enable       = valid_q && wb_en_q && (rd_q != '0) && !misaligned_q;
    assign wb_reg          = rd_q;
    assign load_misaligned = misaligned_q;
    // The faulting address must be visible in the pulse cycle itself, so it
    // is forwarded from the pipeline register and then held in fault_q.
    assign fault_addr      = misaligned_q ? alu_q : fault_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_rv32i_writeback.sv
module tb_rv32i_writeback;
    import rv32i_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_flush, in_wb_en;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_pc_plus4, in_mem_rdata;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wr_data;
    logic        load_misaligned;
    logic [31:0] fault_addr;
    logic [63:0] instret;

    rv32i_writeback #(
        .Reg_width      (32),
        .Reg_depth_bits (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_flush        (in_flush),
        .in_wb_en        (in_wb_en),
        .in_rd           (in_rd),
        .in_wb_sel       (in_wb_sel),
        .in_funct3       (in_funct3),
        .in_alu_result   (in_alu_result),
        .in_pc_plus4     (in_pc_plus4),
        .in_mem_rdata    (in_mem_rdata),
        .wb_enable       (wb_enable),
        .wb_reg          (wb_reg),
        .wr_data         (wr_data),
        .load_misaligned (load_misaligned),
        .fault_addr      (fault_addr),
        .instret         (instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        mis;
        logic [31:0] faddr;
        logic [63:0] ir;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int          writes_seen = 0;

    // Reference state: architecturally visible values after the last edge.
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] m_fault;
    logic [63:0] m_cnt;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * a)) & 32'hFF;
        h = (r >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return r;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [1:0] sel, input logic [2:0] f3,
                                     input logic [1:0] a);
        if (sel != 2'd1) return 1'b0;
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        return a != 2'd0;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] pc4,
                                               input logic [31:0] r);
        case (sel)
            2'd0:    return alu;
            2'd1:    return ref_load(f3, alu[1:0], r);
            2'd2:    return pc4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Drives one cycle of stimulus (called just after a rising edge) and
    // queues the outputs the next edge must produce.
    task automatic issue(input logic rst, input logic v, input logic fl, input logic we,
                         input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] rdat);
        exp_t e;
        logic mis;
        reset = rst; in_valid = v; in_flush = fl; in_wb_en = we; in_rd = rd;
        in_wb_sel = sel; in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
        in_mem_rdata = rdat;
        e.due = cyc + 1;
        e.en  = 1'b0;
        e.mis = 1'b0;
        if (rst) begin
            m_reg = 0; m_data = 0; m_fault = 0; m_cnt = 0;
            e.ir = 0;
        end else begin
            e.ir = m_cnt;
            if (v && !fl) begin
                mis    = ref_mis(sel, f3, alu[1:0]);
                m_reg  = rd;
                m_data = ref_result(sel, f3, alu, pc4, rdat);
                if (mis) m_fault = alu;
                else     m_cnt   = m_cnt + 1;
                e.mis = mis;
                e.en  = we && (rd != 0) && !mis;
            end
        end
        e.rg    = m_reg;
        e.data  = m_data;
        e.faddr = m_fault;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("wb_enable", 64'(wb_enable), 64'(e.en));
            check("load_misaligned", 64'(load_misaligned), 64'(e.mis));
            check("wb_reg", 64'(wb_reg), 64'(e.rg));
            check("wr_data", 64'(wr_data), 64'(e.data));
            check("fault_addr", 64'(fault_addr), 64'(e.faddr));
            check("instret", instret, e.ir);
            if (wb_enable) writes_seen++;
        end
    end

    initial begin
        int w0;
        #1;
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 1, 0, 1, 3, 0, 0, 32'h55, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // LB lane 3 sign-extends 0x80
        issue(0, 1, 0, 1, 5, 2'd1, 3'd0, 32'h0000_1003, 32'h4, 32'h80FF_1234);
        // LHU / LH upper half
        issue(0, 1, 0, 1, 6, 2'd1, 3'd5, 32'h0000_2002, 32'h8, 32'h9ABC_5678);
        issue(0, 1, 0, 1, 7, 2'd1, 3'd1, 32'h0000_2002, 32'hC, 32'h9ABC_5678);
        // misaligned LW, then idle to see the pulse end and fault_addr hold
        issue(0, 1, 0, 1, 8, 2'd1, 3'd2, 32'h0000_1001, 32'h10, 32'hDEAD_BEEF);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU op to x0 still retires
        issue(0, 1, 0, 1, 0, 2'd0, 3'd0, 32'h1234_5678, 32'h14, 0);
        // JAL flushed, then the same unflushed
        issue(0, 1, 1, 1, 1, 2'd2, 3'd0, 32'h0000_0040, 32'h0000_0104, 0);
        issue(0, 1, 0, 1, 1, 2'd2, 3'd0, 32'h0000_0040, 32'h0000_0104, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // five back-to-back ALU writes, reset on the third
        w0 = writes_seen;
        issue(0, 1, 0, 1, 10, 2'd0, 3'd0, 32'hA1, 0, 0);
        issue(0, 1, 0, 1, 11, 2'd0, 3'd0, 32'hA2, 0, 0);
        issue(1, 1, 0, 1, 12, 2'd0, 3'd0, 32'hA3, 0, 0);
        @(negedge clock);
        check("writes_before_reset", 64'(writes_seen - w0), 64'd2);
        @(posedge clock); #1;
        issue(0, 1, 0, 1, 13, 2'd0, 3'd0, 32'hA4, 0, 0);
        issue(0, 1, 0, 1, 14, 2'd0, 3'd0, 32'hA5, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = {a[31:2], 2'($urandom_range(0, 3))};
            issue(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)),
                  a, $urandom, $urandom);
        end
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clock);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_writeback.md
RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 The block SHALL have parameter Reg_width, default 32, meaning datapath and register width.
REQ-002 The block SHALL have parameter Reg_depth_bits, default 5, meaning register index width.
REQ-003 The block SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  MEM-stage instruction present this cycle.
REQ-006 The block SHALL have port in_flush  input  1  kill the MEM-stage instruction this cycle.
REQ-007 The block SHALL have port in_wb_en  input  1  instruction writes rd.
REQ-008 The block SHALL have port in_rd  input  Reg_depth_bits  destination register index.
REQ-009 The block SHALL have port in_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4; 11 reserved.
REQ-010 The block SHALL have port in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 The block SHALL have port in_alu_result  input  Reg_width  ALU result; also the effective load address.
REQ-012 The block SHALL have port in_pc_plus4  input  Reg_width  link value.
REQ-013 The block SHALL have port in_mem_rdata  input  Reg_width  word-aligned memory read data.
REQ-014 The block SHALL have port wb_enable  output  1  register-file write strobe.
REQ-015 The block SHALL have port wb_reg  output  Reg_depth_bits  register-file write index.
REQ-016 The block SHALL have port wr_data  output  Reg_width  register-file write data.
REQ-017 The block SHALL have port load_misaligned  output  1  one-cycle fault pulse.
REQ-018 The block SHALL have port fault_addr  output  Reg_width  address of the last misaligned load.
REQ-019 The block SHALL have port instret  output  64  count of retired instructions.

Function
REQ-020 The block SHALL capture the input fields into a MEM/WB register on the edge where in_valid=1 and in_flush=0; otherwise it SHALL load valid_q=0.
REQ-021 The outputs wb_enable, wb_reg, wr_data and load_misaligned SHALL come from the MEM/WB register, giving a fixed latency of 1 cycle, with no combinational path from the inputs.
REQ-022 The wr_data value SHALL be selected as follows: in_alu_result for sel=00, the aligned load for 01, in_pc_plus4 for 10, and 0 for 11.
REQ-023 The load alignment SHALL use byte lane addr[1:0] for LB/LBU and half lane addr[1] for LH/LHU.
REQ-024 LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend, and LW SHALL pass the full word.
REQ-025 Funct3 codes 011, 110 and 111 with sel=01 SHALL be treated as LW.
REQ-026 A load SHALL be misaligned when it is LH/LHU with addr[0]=1, or LW with addr[1:0]!=00.
REQ-027 The wb_enable output SHALL equal valid_q AND wb_en_q AND (wb_reg_q!=0) AND NOT misaligned_q.
REQ-028 A valid misaligned load SHALL raise load_misaligned for exactly 1 cycle, load fault_addr with its address in that same cycle, and suppress wb_enable.
REQ-029 The fault_addr output SHALL hold its value until the next misaligned load.
REQ-030 The instret counter SHALL increment by 1 for each cycle with valid_q=1 and misaligned_q=0, including instructions with wb_en=0 or rd=0.
REQ-031 The instret counter SHALL wrap from 2^64-1 to 0.
REQ-032 When in_flush=1 and in_valid=1 occur together, flush SHALL win: no writeback, no fault, and no count.
REQ-033 Back-to-back valid instructions SHALL be accepted every cycle with no bubbles.
REQ-034 When in_valid=0, wb_reg and wr_data SHALL hold their last values and wb_enable SHALL be 0.

Reset
REQ-035 Reset SHALL clear valid_q, wb_enable, load_misaligned, wb_reg, wr_data, fault_addr and instret to 0.
REQ-036 Reset asserted during a valid cycle SHALL discard that instruction, with no write and no count.
REQ-037 Reset SHALL take priority over in_valid and in_flush.

Structure
REQ-038 The wb_sel encodings, the load funct3 codes and the 64-bit instret width SHALL be defined in shared package rv32i_pkg.
REQ-039 The sign/zero extraction SHALL be a combinational sub-module rv32i_load_align with inputs funct3, addr[1:0] and rdata, and outputs data and misaligned.
REQ-040 The sub-module rv32i_load_align SHALL be instantiated once, on the registered fields.

Verification
REQ-041 The bench SHALL cover: LB, addr=...3, rdata=0x80FF_1234 -> 1 cycle later wb_enable=1, wr_data=0xFFFF_FF80.
REQ-042 The bench SHALL cover: LHU, addr=...2, rdata=0x9ABC_5678 -> wr_data=0x0000_9ABC; LH at the same address -> 0xFFFF_9ABC.
REQ-043 The bench SHALL cover: LW, addr=0x1001 -> load_misaligned pulses 1 cycle, fault_addr=0x1001, wb_enable=0, and instret unchanged.
REQ-044 The bench SHALL cover: ALU op with rd=0, wb_en=1 -> wb_enable=0, and instret increments by 1.
REQ-045 The bench SHALL cover: in_valid=1 with in_flush=1 for JAL rd=1 -> no write and no count; the same instruction without flush -> wr_data=in_pc_plus4.
REQ-046 The bench SHALL cover: 5 back-to-back ALU writes with reset asserted on the 3rd -> exactly 2 writes before reset and instret=0 after reset.
